add_arb: RTL and testbench
==========================

# add_arb

Two-port round-robin arbiter sharing one registered W-bit adder between two requesters. Each requester presents an operand pair and carry-in with a valid/ready handshake. The winner's operands go to a single adder stage, and the registered sum/carry return on one response channel tagged with the requester id. It sits in front of the adder datapath so that two independent clients can time-share one adder instead of each instantiating its own.

## Interface
- W, 32, operand/sum width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle (when valid)
- req0_a, req0_b  in  W  port 0 operands
- req0_ci  in  1  port 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_ci: same as port 0, for port 1
- rsp_valid  out  1  response slot holds a result
- rsp_ready  in  1  consumer takes response this cycle
- rsp_id  out  1  port that issued the result (0/1)
- s  out  W  sum, {co,s} = a + b + ci
- co  out  1  carry-out

## Operation
- Reset values:
  - rsp_valid=0, rsp_id=0, s=0, co=0.
  - Round-robin pointer last_grant=1, so port 0 wins the first contention.
- Slot free: `free = !rsp_valid || rsp_ready`. A result being drained this cycle frees the slot in the same cycle.
- Grant (combinational):
  - Only one port valid: grant that port.
  - Both valid: grant the port != last_grant.
  - None valid: no grant.
- `reqN_ready = grant==N && free`. Ready depends on valid; requesters must not make valid depend on ready.
- Accept = valid && ready on the granted port. On accept:
  - The adder loads the granted a, b, ci.
  - rsp_id and last_grant load the granted id.
  - rsp_valid is set.
- Drain without a new accept: rsp_valid clears. s, co and rsp_id hold their last values.
- Holding: `rsp_valid && !rsp_ready` stalls both ports, with ready=0. The output stays stable until taken.
- Arithmetic: full W-bit unsigned add. Carry-out is the bit W of the (W+1)-bit sum. Wrap-around in s is expected and not flagged.
- Reset mid-operation: any pending result is discarded (rsp_valid=0) and last_grant returns to 1.

## Timing
- Latency: a request accepted at edge T has rsp_valid=1 with its result during cycle T+1.
- Throughput: one accept per cycle when rsp_ready is held high (back-to-back).
- Under continuous dual contention, grants alternate 0,1,0,1,...
- Simultaneous drain and accept in one cycle: the new result replaces the old one at the edge, and rsp_valid stays 1.
- No combinational path from rsp_ready to s/co/rsp_id.
- A combinational path exists from rsp_ready and reqN_valid to reqN_ready.

## Structure
- Sub-module add32_stage (parameter W):
  - Ports: clk, reset, en, a, b, ci, s, co.
  - Registers {co,s} <= a+b+ci when en. Resets to 0.
  - add_arb drives en with the accept signal.
- Shared package: PORT0=1'b0 and PORT1=1'b1 id constants, and the default W=32.
- The arbiter logic stays in add_arb: grant mux, last_grant register, rsp_valid/rsp_id registers.

## Test plan
- Reset, then port 0 alone sends a=FFFF_FFFF, b=0, ci=1 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, s=0000_0000, co=1.
- Both ports valid on the same cycle (port 0: 0000_FFFF + FFFF_0000, ci=0; port 1: 135F_A562 + 3561_4642, ci=0), rsp_ready=1:
  - First response is id 0, s=FFFF_FFFF, co=0.
  - Second response, on the next cycle, is id 1, s=48C0_EBA4, co=0.
- Both ports held valid for 6 cycles with rsp_ready=1 -> ids alternate 0,1,0,1,0,1, one response per cycle.
- Stall: rsp_ready=0 while a response is pending -> both readys stay 0, and s/co/rsp_id stay stable for 3 cycles. Raising rsp_ready drains the response and accepts the next request in the same cycle.
- Assert reset asynchronously while rsp_valid=1 -> rsp_valid, s and co go to 0 immediately. With both ports valid afterwards, the first grant is port 0.
- Idle: no valid for 4 cycles after a drain -> rsp_valid=0, and s/co hold the last result.

Source files
------------

// File: rtl/add_arb_pkg.sv
// Shared constants for the two-port arbitrated adder.
package add_arb_pkg;

  localparam int unsigned ADD_W = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/add32_stage.sv
// Registered W-bit adder stage: {co,s} <= a + b + ci when enabled.
module add32_stage
  import add_arb_pkg::*;
#(
  parameter int unsigned W = ADD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] sum_d;
  logic [W:0] sum_q;

  // Full-width unsigned add; bit W is the carry-out.
  always_comb begin
    sum_d = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
  end

  // Result register, loaded only on an accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_d;
    end
  end

  assign s  = sum_q[W-1:0];
  assign co = sum_q[W];

endmodule

// File: rtl/add_arb.sv
// Two-port round-robin arbiter time-sharing one registered adder.
module add_arb
  import add_arb_pkg::*;
#(
  parameter int unsigned W = ADD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_ci,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_ci,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] s,
  output logic         co
);

  logic         last_grant_q, last_grant_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;

  logic         free_c;
  logic         grant_vld_c;
  logic         grant_id_c;
  logic         accept_c;
  logic [W-1:0] mux_a_c;
  logic [W-1:0] mux_b_c;
  logic         mux_ci_c;

  // Grant selection, handshake and operand mux.
  always_comb begin
    free_c      = !rsp_valid_q || rsp_ready;
    grant_vld_c = req0_valid || req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id_c = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id_c = PORT1;
    end else begin
      grant_id_c = PORT0;
    end
    accept_c   = grant_vld_c && free_c;
    req0_ready = accept_c && (grant_id_c == PORT0);
    req1_ready = accept_c && (grant_id_c == PORT1);
    mux_a_c    = (grant_id_c == PORT1) ? req1_a  : req0_a;
    mux_b_c    = (grant_id_c == PORT1) ? req1_b  : req0_b;
    mux_ci_c   = (grant_id_c == PORT1) ? req1_ci : req0_ci;
  end

  // Next-state for response slot and round-robin pointer.
  always_comb begin
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    if (accept_c) begin
      last_grant_d = grant_id_c;
      rsp_id_d     = grant_id_c;
      rsp_valid_d  = 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // Control registers; pointer resets to port 1 so port 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= PORT1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= PORT0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  add32_stage #(.W(W)) u_add (
    .clk   (clk),
    .reset (reset),
    .en    (accept_c),
    .a     (mux_a_c),
    .b     (mux_b_c),
    .ci    (mux_ci_c),
    .s     (s),
    .co    (co)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_add_arb.sv
// Bench for add_arb: randomized and directed stimulus, queue-based scoreboard.
module tb_add_arb;
  import add_arb_pkg::*;

  localparam int unsigned W = ADD_W;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req0_ci;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_ci;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, co;
  logic [W-1:0] s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] s;
    logic         co;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t held;
  logic m_last;

  add_arb #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ci    (req0_ci),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ci    (req1_ci),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .s          (s),
    .co         (co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference add: plain integer arithmetic on 64-bit values.
  function automatic rsp_t model_add(input logic id, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic ci);
    rsp_t r;
    longint unsigned t;
    t    = longint'(a) + longint'(b) + longint'(ci);
    r.id = id;
    r.s  = t[W-1:0];
    r.co = t[W];
    return r;
  endfunction

  // Scoreboard/monitor: checks outputs mid-cycle, then predicts the next edge.
  always @(negedge clk) begin : mdl
    rsp_t cur;
    logic pend, free, gv, g;
    if (reset) begin
      exp_q.delete();
      m_last = 1'b1;
      held   = '{1'b0, '0, 1'b0};
    end else begin
      pend = (exp_q.size() != 0);
      cur  = pend ? exp_q[0] : held;
      chk("rsp_valid", 64'(rsp_valid), 64'(pend));
      chk("rsp_id", 64'(rsp_id), 64'(cur.id));
      chk("s", 64'(s), 64'(cur.s));
      chk("co", 64'(co), 64'(cur.co));
      free = !pend || rsp_ready;
      gv   = req0_valid || req1_valid;
      g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
      chk("req0_ready", 64'(req0_ready), 64'(gv && free && !g));
      chk("req1_ready", 64'(req1_ready), 64'(gv && free && g));
      if (pend && rsp_ready) void'(exp_q.pop_front());
      if (gv && free) begin
        held = g ? model_add(1'b1, req1_a, req1_b, req1_ci)
                 : model_add(1'b0, req0_a, req0_b, req0_ci);
        exp_q.push_back(held);
        m_last = g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    req0_a  = $urandom;
    req0_b  = $urandom;
    req0_ci = 1'($urandom_range(1));
    req1_a  = $urandom;
    req1_b  = $urandom;
    req1_ci = 1'($urandom_range(1));
  endtask

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ci = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ci = 1'b0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_s", 64'(s), 64'd0);
    chk("reset_co", 64'(co), 64'd0);
    chk("reset_id", 64'(rsp_id), 64'd0);

    // Port 0 alone, wrap to zero with carry-out.
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = '0; req0_ci = 1'b1;
    step();
    chk("wrap_valid", 64'(rsp_valid), 64'd1);
    chk("wrap_id", 64'(rsp_id), 64'd0);
    chk("wrap_s", 64'(s), 64'h0);
    chk("wrap_co", 64'(co), 64'd1);
    req0_valid = 1'b0;
    step();

    // Fresh pointer, then simultaneous requests.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h0000_FFFF; req0_b = 32'hFFFF_0000; req0_ci = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h135F_A562; req1_b = 32'h3561_4642; req1_ci = 1'b0;
    step();
    chk("cont0_id", 64'(rsp_id), 64'd0);
    chk("cont0_s", 64'(s), 64'hFFFF_FFFF);
    chk("cont0_co", 64'(co), 64'd0);
    req0_valid = 1'b0;
    step();
    chk("cont1_id", 64'(rsp_id), 64'd1);
    chk("cont1_s", 64'(s), 64'h48C0_EBA4);
    chk("cont1_co", 64'(co), 64'd0);
    req1_valid = 1'b0;
    step();

    // Continuous dual contention alternates starting at port 0.
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      step();
      chk("alt_valid", 64'(rsp_valid), 64'd1);
      chk("alt_id", 64'(rsp_id), 64'(i % 2));
    end

    // Stall: both ports blocked while the slot is held.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_r0", 64'(req0_ready), 64'd0);
      chk("stall_r1", 64'(req1_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("unstall_ready", 64'(req0_ready || req1_ready), 64'd1);
    step();
    chk("unstall_valid", 64'(rsp_valid), 64'd1);

    // Asynchronous reset while a result is pending.
    #1 reset = 1'b1;
    #1;
    chk("areset_valid", 64'(rsp_valid), 64'd0);
    chk("areset_s", 64'(s), 64'd0);
    chk("areset_co", 64'(co), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    chk("post_reset_id", 64'(rsp_id), 64'd0);

    // Idle after drain; scoreboard checks s/co hold.
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) step();
    chk("idle_valid", 64'(rsp_valid), 64'd0);

    // Randomized traffic with backpressure.
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom_range(1));
      req1_valid = 1'($urandom_range(1));
      rsp_ready  = ($urandom_range(3) != 0);
      rand_ops();
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
